// File: rtl/inst_fetch_stage.sv
// Instruction fetch front end: issues word fetches over a valid/ready request port with in-order
// responses, buffers up to DEPTH instructions in a prefetch queue and presents {inst, pc} to decode.
// A redirect flushes the queue and discards every response still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched_o / perf_flushed_o event counters.
module inst_fetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_flushed_o,
`endif
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] outst_q, outst_d;
    logic [PtrW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     inst_pc_q, inst_pc_d;

    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];

    logic            req_valid;
    logic            accept;
    logic            pop;
    logic            rsp_drop;
    logic            fill_en;
    logic [PtrW-1:0] alloc_cnt;
    logic [IdxW-1:0] head_idx;

    // Handshake decode: issue gating, accept, pop and response routing.
    always_comb begin
        alloc_cnt = alloc_ptr_q - rd_ptr_q;
        req_valid = !rst_i && !redirect_valid_i && (alloc_cnt < DepthP) && (outst_q < DepthP);
        accept    = req_valid && imem_req_ready_i;
        // A pop coinciding with a redirect is ignored; the head is flushed instead.
        pop       = inst_valid_q && inst_ready_i && !redirect_valid_i;
        rsp_drop  = imem_rsp_valid_i && (drop_cnt_q != '0);
        fill_en   = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
    end

    // Next-state for fetch address, queue pointers and in-flight bookkeeping.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        outst_d     = outst_q;
        drop_cnt_d  = drop_cnt_q;
        if (redirect_valid_i) begin
            fetch_pc_d  = redirect_pc_i & 32'hFFFF_FFFC;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            // Everything still in flight is stale; a same-cycle response is discarded here.
            outst_d     = outst_q - PtrW'(imem_rsp_valid_i);
            drop_cnt_d  = outst_q - PtrW'(imem_rsp_valid_i);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            alloc_ptr_d = alloc_ptr_q + PtrW'(accept);
            fill_ptr_d  = fill_ptr_q + PtrW'(fill_en);
            rd_ptr_d    = rd_ptr_q + PtrW'(pop);
            outst_d     = outst_q + PtrW'(accept) - PtrW'(imem_rsp_valid_i);
            drop_cnt_d  = drop_cnt_q - PtrW'(rsp_drop);
        end
    end

    // Registered head: next head slot, bypassing a response that fills it this cycle.
    always_comb begin
        head_idx     = rd_ptr_d[IdxW-1:0];
        inst_valid_d = !redirect_valid_i && (fill_ptr_d != rd_ptr_d);
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (inst_valid_d) begin
            inst_pc_d = pc_mem_q[head_idx];
            if (fill_en && (fill_ptr_q[IdxW-1:0] == head_idx)) begin
                inst_d = imem_rsp_data_i;
            end else begin
                inst_d = data_mem_q[head_idx];
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q   <= RESET_PC;
            alloc_ptr_q  <= '0;
            fill_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            outst_q      <= '0;
            drop_cnt_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            alloc_ptr_q  <= alloc_ptr_d;
            fill_ptr_q   <= fill_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            outst_q      <= outst_d;
            drop_cnt_q   <= drop_cnt_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // Queue storage: pc captured at accept, instruction word at live response.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pc_mem_q[alloc_ptr_q[IdxW-1:0]] <= fetch_pc_q;
        end
        if (fill_en) begin
            data_mem_q[fill_ptr_q[IdxW-1:0]] <= imem_rsp_data_i;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] flush_inc;

    // Flushed events: discarded responses plus filled entries thrown away by a redirect.
    always_comb begin
        flush_inc = 32'(rsp_drop);
        if (redirect_valid_i) begin
            flush_inc = 32'(fill_ptr_q - rd_ptr_q) + 32'(imem_rsp_valid_i);
        end
    end

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_flushed_q <= perf_flushed_q + flush_inc;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_flushed_o = perf_flushed_q;
`endif

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign inst_valid_o     = inst_valid_q;
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage (DEPTH=4): behavioural memory with configurable latency, a
// cycle-by-cycle vector table for the basic pipeline, and hand-written redirect/stall sequences.
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    inst_fetch_stage #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched_o   (perf_fetched),
        .perf_flushed_o   (perf_flushed),
`endif
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } pop_t;
    typedef struct {
        logic        ir;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    pop_t        got[$];
    vec_t        vecs[10];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8c010004;
        if (a == 32'h4) return 32'h00221820;
        return 32'hC0DE0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_pop(input int idx, input logic [31:0] exp_pc);
        if (idx >= got.size()) begin
            checks++;
            errors++;
            $display("FAIL pop%0d: got no instruction expected pc %h", idx, exp_pc);
        end else begin
            chk($sformatf("pop%0d_pc", idx), got[idx].pc, exp_pc);
            chk($sformatf("pop%0d_inst", idx), got[idx].word, mem_word(exp_pc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory response side: in-order, each response `lat` cycles after its accept.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend[0].addr);
            pend.delete(0);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    end

    // Monitor: record accepted requests and consumed instructions.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (req_valid && req_ready) begin
                pend.push_back('{req_addr, cyc + lat});
                acc_log.push_back(req_addr);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                got.push_back('{inst_pc, inst});
            end
        end
    end

    // Bookkeeping invariant: alloc_cnt + drop_cnt == outstanding + filled_unpopped.
    always @(negedge clk) begin
        logic [2:0] lhs;
        if (!rst) begin
            lhs = dut.alloc_ptr_q - dut.fill_ptr_q + dut.drop_cnt_q;
            chk("invariant", {29'd0, lhs}, {29'd0, dut.outst_q});
        end
    end

    // Holds reset, checks the reset state, returns in cycle 1 after release.
    task automatic do_reset(input int lat_v);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        req_ready      = 1'b1;
        lat            = lat_v;
        tick();
        @(negedge clk);
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        acc_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        req_ready      = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Zero-wait memory from reset release; ready drops for three cycles late in the run.
        vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[7] = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
        vecs[8] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
        vecs[9] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

        // Basic pipeline, latency and backpressure from the vector table.
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            inst_ready = vecs[i].ir;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), {31'd0, req_valid}, {31'd0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), req_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_iv});
            if (vecs[i].exp_iv) begin
                chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].exp_pc));
            end
            tick();
        end

        // Consumer stalled: queue fills with exactly DEPTH accepts, then drains in order.
        do_reset(1);
        repeat (8) tick();
        @(negedge clk);
        chk("full_req_valid", {31'd0, req_valid}, 32'd0);
        chk("full_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("full_inst_pc", inst_pc, 32'h0);
        chk("full_accepts", acc_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_log.size()) chk($sformatf("full_acc%0d", i), acc_log[i], 32'(4 * i));
        end
        tick();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("drain_req_valid0", {31'd0, req_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("drain_req_valid1", {31'd0, req_valid}, 32'd1);
        chk("drain_req_addr", req_addr, 32'h10);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) chk_pop(i, 32'(4 * i));

        // Latency-3 memory, redirect with two fetches in flight.
        do_reset(3);
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        chk("redir_req_valid", {31'd0, req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_req_addr", req_addr, 32'h40);
        repeat (10) tick();
        chk_pop(0, 32'h40);
        chk_pop(1, 32'h44);

        // Request held for five cycles without ready: stable address, single accept.
        do_reset(1);
        inst_ready = 1'b1;
        tick();
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", i), {31'd0, req_valid}, 32'd1);
            chk($sformatf("hold%0d_addr", i), req_addr, 32'h8);
            tick();
        end
        req_ready = 1'b1;
        @(negedge clk);
        chk("hold_accept_addr", req_addr, 32'h8);
        tick();
        @(negedge clk);
        chk("hold_next_addr", req_addr, 32'hC);
        tick();
        chk("hold_accepts", acc_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_log.size()) chk($sformatf("hold_acc%0d", i), acc_log[i], 32'(4 * i));
        end

        // Redirect to unaligned pc coinciding with a response and a pop.
        do_reset(2);
        inst_ready = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        chk("r5_head_pc", inst_pc, 32'h4);
        chk("r5_head_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("r5_req_addr", req_addr, 32'h100);
        chk("r5_iv_c6", {31'd0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("r5_iv_c7", {31'd0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("r5_iv_c8", {31'd0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("r5_iv_c9", {31'd0, inst_valid}, 32'd1);
        chk("r5_pc_c9", inst_pc, 32'h100);
        repeat (3) tick();
        chk_pop(0, 32'h0);
        chk_pop(1, 32'h100);
        chk_pop(2, 32'h104);

`ifdef FETCH_PERF_CNT_EN
        // Ten pops, then redirect with three filled entries and one same-cycle response.
        do_reset(1);
        inst_ready = 1'b1;
        repeat (12) tick();
        inst_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_flushed", perf_flushed, 32'd4);
        chk("perf_pops", got.size(), 32'd10);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
